// File: rtl/apb_burst_master.sv
// APB-side stage of the AXI2APB bridge: takes one burst command and runs it
// as a series of single APB transfers, with per-beat read data or one write response.
module apb_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // burst command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  // write-data FIFO
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  // read beats
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  // write response
  output logic                  bresp_valid,
  input  logic                  bresp_ready,
  output logic [1:0]            bresp,
  // APB
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    R_PUSH = 3'd4,
    B_RESP = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [3:0]              cnt_q;
  logic                    last_q;
  logic [1:0]              bresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [3:0]              pstrb_q;
  logic [ADDR_WIDTH-1:0]   addr_step;
  logic                    beat_done;

  assign beat_done = (state_q == ACCESS) && pready;

  // Beat size is clamped to the 32-bit bus width.
  always_comb begin
    addr_step = ADDR_WIDTH'(4);
    if (size_q == 3'd0) begin
      addr_step = ADDR_WIDTH'(1);
    end else if (size_q == 3'd1) begin
      addr_step = ADDR_WIDTH'(2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_write ? WAIT_W : SETUP;
        end
      end
      WAIT_W: begin
        if (wdata_valid) begin
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (!write_q) begin
            state_d = R_PUSH;
          end else if (cnt_q == 4'd0) begin
            state_d = B_RESP;
          end else begin
            state_d = WAIT_W;
          end
        end
      end
      R_PUSH: begin
        if (rdata_ready) begin
          state_d = last_q ? IDLE : SETUP;
        end
      end
      B_RESP: begin
        if (bresp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    rdata_valid = 1'b0;
    bresp_valid = 1'b0;
    case (state_q)
      IDLE:   cmd_ready   = 1'b1;
      WAIT_W: wdata_ready = 1'b1;
      SETUP:  psel        = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      R_PUSH: rdata_valid = 1'b1;
      B_RESP: bresp_valid = 1'b1;
      default: ;
    endcase
    pwrite = psel & write_q;
  end

  // last_q remembers whether the completed beat was the final one, so the
  // counter never has to go below zero while the response is still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      bresp_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        write_q  <= cmd_write;
        addr_q   <= cmd_addr;
        size_q   <= cmd_size;
        burst_q  <= cmd_burst;
        cnt_q    <= cmd_len;
        last_q   <= 1'b0;
        bresp_q  <= 2'b00;
        pwdata_q <= '0;
        pstrb_q  <= 4'h0;
      end
      if (state_q == WAIT_W && wdata_valid) begin
        pwdata_q <= wdata;
        pstrb_q  <= wstrb;
      end
      if (beat_done) begin
        if (burst_q != 2'b00) begin
          addr_q <= addr_q + addr_step;
        end
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end
        last_q <= (cnt_q == 4'd0);
        if (!write_q) begin
          rdata_q <= prdata;
          rresp_q <= pslverr ? 2'b10 : 2'b00;
        end else if (pslverr) begin
          bresp_q <= 2'b10;
        end
      end
    end
  end

  assign paddr  = addr_q;
  assign pwdata = pwdata_q;
  assign pstrb  = write_q ? pstrb_q : 4'h0;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = (state_q == R_PUSH) && last_q;
  assign bresp  = bresp_q;

endmodule

// File: tb/tb_apb_burst_master.sv
// Directed bench for apb_burst_master: scripted APB slave, write FIFO and
// response sinks, with logs of every completed transfer compared to hand values.
module tb_apb_burst_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        bresp_valid;
  logic        bresp_ready;
  logic [1:0]  bresp;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  st;
  } apb_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  apb_t        apb_log[$];
  rbeat_t      rd_log[$];
  logic [1:0]  b_log[$];

  logic [31:0] fifo_mem[8];
  logic [3:0]  fifo_strb;
  int          fifo_ptr;
  int          fifo_n;
  logic        fifo_en;
  logic [31:0] err_addr;

  int n_checks;
  int n_errors;

  apb_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast),
    .bresp_valid(bresp_valid), .bresp_ready(bresp_ready), .bresp(bresp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave read data is a fixed function of the address; errors on one address.
  assign prdata      = 32'hC0DE_0000 ^ paddr;
  assign pslverr     = psel && penable && (paddr == err_addr);
  assign wdata_valid = fifo_en && (fifo_ptr < fifo_n);
  assign wdata       = fifo_mem[fifo_ptr[2:0]];
  assign wstrb       = fifo_strb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Records what the coming edge completes, then advances one cycle.
  task automatic tick();
    logic pop;
    if (psel && penable && pready) begin
      apb_log.push_back('{addr: paddr, wr: pwrite, wd: pwdata, st: pstrb});
      $display("apb  %s addr=%h wdata=%h strb=%h err=%0d", pwrite ? "wr" : "rd",
               paddr, pwdata, pstrb, pslverr);
    end
    if (rdata_valid && rdata_ready) begin
      rd_log.push_back('{data: rdata, resp: rresp, last: rlast});
      $display("rbeat data=%h resp=%0d last=%0d", rdata, rresp, rlast);
    end
    if (bresp_valid && bresp_ready) begin
      b_log.push_back(bresp);
      $display("bresp resp=%0d", bresp);
    end
    pop = wdata_valid && wdata_ready;
    @(posedge clk);
    #1;
    if (pop) fifo_ptr++;
  endtask

  task automatic clear_logs();
    apb_log.delete();
    rd_log.delete();
    b_log.delete();
  endtask

  task automatic load_fifo(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input int n);
    fifo_mem[0] = w0;
    fifo_mem[1] = w1;
    fifo_mem[2] = w2;
    fifo_ptr    = 0;
    fifo_n      = n;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    check_eq("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      if (cmd_ready) done = 1'b1;
    end
    check_eq("burst_completes_in_budget", 32'(done), 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_size    = '0;
    cmd_burst   = '0;
    rdata_ready = 1'b1;
    bresp_ready = 1'b1;
    pready      = 1'b1;
    fifo_strb   = 4'hF;
    fifo_en     = 1'b0;
    err_addr    = 32'hFFFF_FFF0;
    load_fifo(32'h0, 32'h0, 32'h0, 0);

    // Reset state
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_psel", 32'(psel), 32'd0);
    check_eq("rst_penable", 32'(penable), 32'd0);
    check_eq("rst_paddr", paddr, 32'h0);
    check_eq("rst_valids", {29'd0, rdata_valid, bresp_valid, wdata_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Read INCR, 4 beats, with latency checks
    clear_logs();
    send_cmd(1'b0, 32'h1000, 4'd3, 3'd2, 2'b01);
    check_eq("rd_setup_psel_penable", {30'd0, psel, penable}, 32'd2);
    check_eq("rd_setup_paddr", paddr, 32'h1000);
    check_eq("rd_setup_pwrite", 32'(pwrite), 32'd0);
    tick();
    check_eq("rd_access_psel_penable", {30'd0, psel, penable}, 32'd3);
    tick();
    check_eq("rd_first_rvalid", 32'(rdata_valid), 32'd1);
    check_eq("rd_first_rdata", rdata, 32'hC0DE1000);
    check_eq("rd_push_psel", 32'(psel), 32'd0);
    wait_idle(40);
    check_eq("rd_incr_xfers", 32'(apb_log.size()), 32'd4);
    check_eq("rd_incr_beats", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea;
      ea = 32'h1000 + 32'(4 * i);
      if (i < apb_log.size()) check_eq("rd_incr_paddr", apb_log[i].addr, ea);
      if (i < rd_log.size()) begin
        check_eq("rd_incr_rdata", rd_log[i].data, 32'hC0DE_0000 ^ ea);
        check_eq("rd_incr_rresp", 32'(rd_log[i].resp), 32'd0);
        check_eq("rd_incr_rlast", 32'(rd_log[i].last), (i == 3) ? 32'd1 : 32'd0);
      end
    end

    // Write FIXED, 2 beats
    clear_logs();
    load_fifo(32'hAAAA0001, 32'hBBBB0002, 32'h0, 2);
    fifo_en = 1'b1;
    send_cmd(1'b1, 32'h2000, 4'd1, 3'd2, 2'b00);
    check_eq("wr_waitw_wdata_ready", 32'(wdata_ready), 32'd1);
    tick();
    check_eq("wr_setup_psel_penable", {30'd0, psel, penable}, 32'd2);
    check_eq("wr_setup_pwdata", pwdata, 32'hAAAA0001);
    check_eq("wr_setup_pwrite", 32'(pwrite), 32'd1);
    wait_idle(40);
    check_eq("wr_fixed_xfers", 32'(apb_log.size()), 32'd2);
    if (apb_log.size() == 2) begin
      check_eq("wr_fixed_addr0", apb_log[0].addr, 32'h2000);
      check_eq("wr_fixed_addr1", apb_log[1].addr, 32'h2000);
      check_eq("wr_fixed_data0", apb_log[0].wd, 32'hAAAA0001);
      check_eq("wr_fixed_data1", apb_log[1].wd, 32'hBBBB0002);
      check_eq("wr_fixed_strb", 32'(apb_log[1].st), 32'hF);
    end
    check_eq("wr_fixed_nbresp", 32'(b_log.size()), 32'd1);
    if (b_log.size() == 1) check_eq("wr_fixed_bresp", 32'(b_log[0]), 32'd0);

    // Write INCR with slave error on beat 2 of 3
    clear_logs();
    load_fifo(32'h11, 32'h22, 32'h33, 3);
    err_addr = 32'h3004;
    send_cmd(1'b1, 32'h3000, 4'd2, 3'd2, 2'b01);
    wait_idle(60);
    err_addr = 32'hFFFF_FFF0;
    check_eq("wr_err_xfers", 32'(apb_log.size()), 32'd3);
    if (apb_log.size() == 3) check_eq("wr_err_addr2", apb_log[2].addr, 32'h3008);
    check_eq("wr_err_nbresp", 32'(b_log.size()), 32'd1);
    if (b_log.size() == 1) check_eq("wr_err_bresp", 32'(b_log[0]), 32'd2);
    fifo_en = 1'b0;

    // pready low 5 cycles, then rdata_ready low 3 cycles (halfword INCR)
    clear_logs();
    pready = 1'b0;
    send_cmd(1'b0, 32'h4000, 4'd1, 3'd1, 2'b01);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_access_psel_penable", {30'd0, psel, penable}, 32'd3);
      check_eq("stall_access_paddr", paddr, 32'h4000);
      if (i < 4) tick();
    end
    pready      = 1'b1;
    rdata_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_rpush_valid", 32'(rdata_valid), 32'd1);
      check_eq("stall_rpush_rdata", rdata, 32'hC0DE4000);
      check_eq("stall_rpush_paddr", paddr, 32'h4002);
      if (i < 2) tick();
    end
    rdata_ready = 1'b1;
    wait_idle(40);
    check_eq("stall_xfers", 32'(apb_log.size()), 32'd2);
    check_eq("stall_beats", 32'(rd_log.size()), 32'd2);
    if (apb_log.size() == 2) check_eq("stall_addr1", apb_log[1].addr, 32'h4002);
    if (rd_log.size() == 2) check_eq("stall_last", {31'd0, rd_log[1].last}, 32'd1);

    // Write FIFO empty for 4 cycles between beats
    clear_logs();
    load_fifo(32'h11111111, 32'h22222222, 32'h0, 2);
    fifo_en = 1'b1;
    send_cmd(1'b1, 32'h6000, 4'd1, 3'd2, 2'b01);
    tick();
    fifo_en = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("gap_psel", 32'(psel), 32'd0);
      check_eq("gap_wdata_ready", 32'(wdata_ready), 32'd1);
      if (i < 3) tick();
    end
    fifo_en = 1'b1;
    tick();
    check_eq("gap_resume_psel_penable", {30'd0, psel, penable}, 32'd2);
    check_eq("gap_resume_pwdata", pwdata, 32'h22222222);
    check_eq("gap_resume_paddr", paddr, 32'h6004);
    wait_idle(40);
    check_eq("gap_xfers", 32'(apb_log.size()), 32'd2);
    check_eq("gap_nbresp", 32'(b_log.size()), 32'd1);
    fifo_en = 1'b0;

    // Reset during ACCESS of beat 2
    clear_logs();
    send_cmd(1'b0, 32'h7000, 4'd3, 3'd2, 2'b01);
    tick();
    tick();
    tick();
    tick();
    check_eq("abort_pre_paddr", paddr, 32'h7004);
    check_eq("abort_pre_penable", 32'(penable), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_psel_penable", {30'd0, psel, penable}, 32'd0);
    check_eq("abort_valids", {30'd0, rdata_valid, bresp_valid}, 32'd0);
    check_eq("abort_paddr", paddr, 32'h0);
    check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
    send_cmd(1'b0, 32'h5000, 4'd1, 3'd3, 2'b01);
    wait_idle(40);
    check_eq("post_rst_xfers", 32'(apb_log.size()), 32'd2);
    check_eq("post_rst_beats", 32'(rd_log.size()), 32'd2);
    if (apb_log.size() == 2) begin
      check_eq("post_rst_addr0", apb_log[0].addr, 32'h5000);
      check_eq("post_rst_addr1", apb_log[1].addr, 32'h5004);
    end
    if (rd_log.size() == 2) check_eq("post_rst_rdata1", rd_log[1].data, 32'hC0DE5004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
